// File: rtl/data_mem_unit.sv
// data_mem_unit: single-port 64-bit data memory behind a valid/ready request
// port. Each accepted request is either answered at once (no-op, illegal or
// faulting access) or spends LATENCY cycles in ACCESS before a one-cycle
// response. Memory words are not reset.
module data_mem_unit #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic        resp_valid,
    output logic [63:0] ReadData,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rd_q;
    logic        wr_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        resp_valid_q;
    logic        err_q;
    logic [63:0] rdata_q;

    logic [63:0] mem_q [DEPTH];

    // Decode of the incoming request and of the latched access
    logic          misalign_d;
    logic          out_of_range_d;
    logic          mem_op_d;
    logic          fault_d;
    logic          access_done_d;
    logic [AW-1:0] widx_d;
    logic          unused_addr_bits;

    assign misalign_d     = |Address[2:0];
    assign out_of_range_d = |Address[63:AW+3];
    // Exactly one of load/store means a real memory access
    assign mem_op_d       = MemRead ^ MemWrite;
    // Both strobes set is illegal; a real access with a bad address faults
    assign fault_d        = (MemRead & MemWrite) |
                            (mem_op_d & (misalign_d | out_of_range_d));
    assign widx_d         = addr_q[3 +: AW];
    assign access_done_d  = (state_q == ACCESS) && (cnt_q == 4'd0);
    // Range and alignment were already checked on the live address
    assign unused_addr_bits = ^{addr_q[63:AW+3], addr_q[2:0]};

    // req_ready is forced low while reset is held, even though state is IDLE
    assign req_ready  = resetl & (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign err        = err_q;
    assign ReadData   = rdata_q;

    // Request FSM with registered response outputs
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    if (req_valid) begin
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        addr_q  <= Address;
                        wdata_q <= WriteData;
                        if (fault_d || !mem_op_d) begin
                            // No-op, illegal and faulting requests answer
                            // immediately and clear ReadData
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= fault_d;
                            rdata_q      <= 64'd0;
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        // Stores leave ReadData untouched
                        if (rd_q) begin
                            rdata_q <= mem_q[widx_d];
                        end
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                end
            endcase
        end
    end

    // Store write port; a reset before the final ACCESS cycle cancels it
    always_ff @(posedge CLK) begin
        if (access_done_d && wr_q) begin
            mem_q[widx_d] <= wdata_q;
        end
    end

endmodule
